// File: rtl/vx_kmu_cta_dispatcher_pkg.sv
// Shared types for the KMU CTA dispatcher: request payload, FSM states and
// the last-warp thread mask helper.
package VX_kmu_pkg;

  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 4;
  localparam int XLEN        = 32;
  localparam int LOG2_NT     = $clog2(NUM_THREADS);
  localparam int NW_W        = $clog2(NUM_WARPS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_DONE
  } kmu_state_e;

  typedef struct packed {
    logic [NW_W-1:0]        num_warps;
    logic [XLEN-1:0]        start_pc;
    logic [XLEN-1:0]        param;
    logic [31:0]            cta_x;
    logic [31:0]            cta_y;
    logic [31:0]            cta_z;
    logic [31:0]            cta_id;
    logic [NUM_THREADS-1:0] remain_mask;
  } kmu_req_data_t;

  // A partial last warp enables only its low 'rem' lanes; a full one enables all.
  function automatic logic [NUM_THREADS-1:0] remain_mask_f(input logic [LOG2_NT-1:0] rem);
    logic [NUM_THREADS-1:0] one_hot;
    if (rem == '0) begin
      return '1;
    end
    one_hot      = '0;
    one_hot[rem] = 1'b1;
    return one_hot - {{(NUM_THREADS-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/vx_kmu_cta_dispatcher_counter.sv
// Three-dimensional CTA position counter (x fastest) with a linear CTA id
// and a flag marking the final CTA of the grid.
module vx_kmu_cta_counter
  import VX_kmu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        step,
  input  logic [31:0] grid_x,
  input  logic [31:0] grid_y,
  input  logic [31:0] grid_z,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [31:0] z,
  output logic [31:0] id,
  output logic        last
);

  logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d, id_q, id_d;
  logic        x_wrap, y_wrap;

  always_comb begin
    x_wrap = (x_q == grid_x - 32'd1);
    y_wrap = (y_q == grid_y - 32'd1);
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    id_d   = id_q;
    if (clear) begin
      x_d  = '0;
      y_d  = '0;
      z_d  = '0;
      id_d = '0;
    end else if (step) begin
      id_d = id_q + 32'd1;
      if (x_wrap) begin
        x_d = '0;
        if (y_wrap) begin
          y_d = '0;
          z_d = z_q + 32'd1;
        end else begin
          y_d = y_q + 32'd1;
        end
      end else begin
        x_d = x_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      z_q  <= '0;
      id_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      z_q  <= z_d;
      id_q <= id_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign z    = z_q;
  assign id   = id_q;
  assign last = x_wrap & y_wrap & (z_q == grid_z - 32'd1);

endmodule

// File: rtl/vx_kmu_cta_dispatcher.sv
// Turns one kernel launch descriptor into a stream of per-CTA KMU requests.
// Optional macro VX_KMU_ABORT_EN adds an 'abort' input that ends a launch early.
module vx_kmu_cta_dispatcher
  import VX_kmu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [XLEN-1:0] start_pc,
  input  logic [XLEN-1:0] start_param,
  input  logic [31:0]     grid_x,
  input  logic [31:0]     grid_y,
  input  logic [31:0]     grid_z,
  input  logic [31:0]     block_size,
`ifdef VX_KMU_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic            done_err,
  output logic            req_valid,
  input  logic            req_ready,
  output kmu_req_data_t   req_data
);

  kmu_state_e             state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d, param_q, param_d;
  logic [31:0]            gx_q, gx_d, gy_q, gy_d, gz_q, gz_d, bs_q, bs_d;
  logic [NW_W-1:0]        nw_q, nw_d;
  logic [NUM_THREADS-1:0] mask_q, mask_d;
  logic                   err_q, err_d;
  logic [32:0]            nw_calc;
  logic                   cfg_bad, abort_hit;
  logic                   cnt_clear, cnt_step, cnt_last;
  logic [31:0]            cta_x, cta_y, cta_z, cta_id;

`ifdef VX_KMU_ABORT_EN
  logic abort_q, abort_d;

  // Sticky for the rest of the launch so a request stalled at abort time still completes.
  always_comb begin
    abort_d = abort_q;
    if (state_q == ST_IDLE) begin
      abort_d = 1'b0;
    end else if ((state_q == ST_SETUP) || (state_q == ST_ISSUE)) begin
      abort_d = abort_q | abort;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) abort_q <= 1'b0;
    else       abort_q <= abort_d;
  end

  assign abort_hit = abort_q | abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Warp count is formed in 33 bits so block sizes near 2^32 cannot wrap to a small value.
  assign nw_calc = ({1'b0, bs_q} + 33'(NUM_THREADS - 1)) >> LOG2_NT;
  assign cfg_bad = (gx_q == '0) || (gy_q == '0) || (gz_q == '0) || (bs_q == '0) ||
                   (nw_calc > 33'(NUM_WARPS));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    param_d   = param_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    gz_d      = gz_q;
    bs_d      = bs_q;
    nw_d      = nw_q;
    mask_d    = mask_q;
    err_d     = err_q;
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          pc_d    = start_pc;
          param_d = start_param;
          gx_d    = grid_x;
          gy_d    = grid_y;
          gz_d    = grid_z;
          bs_d    = block_size;
          err_d   = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_clear = 1'b1;
        nw_d      = nw_calc[NW_W-1:0];
        mask_d    = remain_mask_f(bs_q[LOG2_NT-1:0]);
        if (cfg_bad || abort_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_ready) begin
          cnt_step = 1'b1;
          if (cnt_last) begin
            state_d = ST_DONE;
          end else if (abort_hit) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      param_q <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      gz_q    <= '0;
      bs_q    <= '0;
      nw_q    <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      param_q <= param_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      gz_q    <= gz_d;
      bs_q    <= bs_d;
      nw_q    <= nw_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  vx_kmu_cta_counter u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .step   (cnt_step),
    .grid_x (gx_q),
    .grid_y (gy_q),
    .grid_z (gz_q),
    .x      (cta_x),
    .y      (cta_y),
    .z      (cta_z),
    .id     (cta_id),
    .last   (cnt_last)
  );

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign done_err    = done & err_q;
  assign req_valid   = (state_q == ST_ISSUE);

  always_comb begin
    req_data             = '0;
    req_data.num_warps   = nw_q;
    req_data.start_pc    = pc_q;
    req_data.param       = param_q;
    req_data.cta_x       = cta_x;
    req_data.cta_y       = cta_y;
    req_data.cta_z       = cta_z;
    req_data.cta_id      = cta_id;
    req_data.remain_mask = mask_q;
  end

endmodule

// File: tb/tb_vx_kmu_cta_dispatcher.sv
// Self-checking bench for vx_kmu_cta_dispatcher: a queue-based launch model is
// compared against the KMU request stream every cycle, plus directed literal checks.
module tb_vx_kmu_cta_dispatcher;
  import VX_kmu_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_valid;
  logic            start_ready;
  logic [XLEN-1:0] start_pc;
  logic [XLEN-1:0] start_param;
  logic [31:0]     grid_x, grid_y, grid_z, block_size;
  logic            busy, done, done_err;
  logic            req_valid;
  logic            req_ready;
  kmu_req_data_t   req_data;
`ifdef VX_KMU_ABORT_EN
  logic            abort = 1'b0;
`endif

  kmu_req_data_t exp_q[$];
  logic          exp_err;
  kmu_req_data_t prev_data;
  int            checks = 0;
  int            passes = 0;
  int            fire_cnt = 0;
  bit            mon_en = 1'b0;
  bit            stall_prev = 1'b0;
  bit            ready_toggle = 1'b0;

  vx_kmu_cta_dispatcher dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_pc    (start_pc),
    .start_param (start_param),
    .grid_x      (grid_x),
    .grid_y      (grid_y),
    .grid_z      (grid_z),
    .block_size  (block_size),
`ifdef VX_KMU_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .done_err    (done_err),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Optional back-pressure: flip req_ready every cycle just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) req_ready = ~req_ready;
    end
  end

  // Global time bound so a stuck DUT can never hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Expected request list for a launch: every CTA in x-fastest order,
  // warps = ceil(block/threads), mask from the leftover thread count.
  task automatic buildModel(input logic [31:0] gx, input logic [31:0] gy, input logic [31:0] gz,
                            input logic [31:0] bs, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] prm);
    longint        nw;
    int            rem;
    int            id;
    kmu_req_data_t r;
    exp_q.delete();
    nw      = (longint'(bs) + NUM_THREADS - 1) / NUM_THREADS;
    rem     = int'(bs % NUM_THREADS);
    exp_err = (gx == 0) || (gy == 0) || (gz == 0) || (bs == 0) || (nw > NUM_WARPS);
    if (!exp_err) begin
      id = 0;
      for (int zz = 0; zz < int'(gz); zz++) begin
        for (int yy = 0; yy < int'(gy); yy++) begin
          for (int xx = 0; xx < int'(gx); xx++) begin
            r.num_warps   = NW_W'(nw);
            r.start_pc    = pc;
            r.param       = prm;
            r.cta_x       = 32'(xx);
            r.cta_y       = 32'(yy);
            r.cta_z       = 32'(zz);
            r.cta_id      = 32'(id);
            r.remain_mask = (rem == 0) ? '1 : NUM_THREADS'((1 << rem) - 1);
            exp_q.push_back(r);
            id++;
          end
        end
      end
    end
  endtask

  // Compare process: every valid request must match the head of the model queue,
  // stalled requests must hold their payload, and done must agree with the model.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (req_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_req", 256'(req_valid), 256'(1'b0));
        end else begin
          checkOutput("req_data", 256'(req_data), 256'(exp_q[0]));
          if (stall_prev) checkOutput("req_stable", 256'(req_data), 256'(prev_data));
          if (req_ready) begin
            void'(exp_q.pop_front());
            fire_cnt++;
          end
        end
      end
      stall_prev = req_valid && !req_ready;
      prev_data  = req_data;
      if (done) begin
        checkOutput("done_err", 256'(done_err), 256'(exp_err));
        checkOutput("done_all_reqs_issued", 256'(exp_q.size()), 256'(0));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] gx, input logic [31:0] gy, input logic [31:0] gz,
                               input logic [31:0] bs, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] prm);
    int guard;
    @(posedge clk);
    #1;
    guard = 0;
    while (!start_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("start_ready_before_launch", 256'(start_ready), 256'(1'b1));
    buildModel(gx, gy, gz, bs, pc, prm);
    fire_cnt    = 0;
    stall_prev  = 1'b0;
    start_pc    = pc;
    start_param = prm;
    grid_x      = gx;
    grid_y      = gy;
    grid_z      = gz;
    block_size  = bs;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic waitDone(input int exp_fires, input int exp_lat, input logic exp_err_lit);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", 256'(seen), 256'(1'b1));
    checkOutput("fire_count", 256'(fire_cnt), 256'(exp_fires));
    checkOutput("done_err_literal", 256'(done_err), 256'(exp_err_lit));
    if (exp_lat >= 0) checkOutput("done_latency", 256'(lat), 256'(exp_lat));
    @(negedge clk);
    checkOutput("start_ready_after_done", 256'(start_ready), 256'(1'b1));
    checkOutput("single_done_pulse", 256'(done), 256'(1'b0));
  endtask

  task automatic runLaunch(input logic [31:0] gx, input logic [31:0] gy, input logic [31:0] gz,
                           input logic [31:0] bs, input int exp_fires, input int exp_lat,
                           input logic exp_err_lit);
    applyStimulus(gx, gy, gz, bs, 32'h8000_0000 + bs, 32'h0000_1000 + gx);
    checkOutput("busy_after_start", 256'(busy), 256'(1'b1));
    waitDone(exp_fires, exp_lat, exp_err_lit);
  endtask

  // Directed sequence.
  initial begin
    int  cnt;
    bit  found;
    reset       = 1'b1;
    start_valid = 1'b0;
    start_pc    = '0;
    start_param = '0;
    grid_x      = '0;
    grid_y      = '0;
    grid_z      = '0;
    block_size  = '0;
    req_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_start_ready", 256'(start_ready), 256'(1'b1));
    checkOutput("reset_busy", 256'(busy), 256'(1'b0));
    checkOutput("reset_done", 256'(done), 256'(1'b0));
    checkOutput("reset_req_valid", 256'(req_valid), 256'(1'b0));
    checkOutput("reset_req_data", 256'(req_data), 256'(0));
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Pin the model itself with hand-computed values.
    buildModel(32'd2, 32'd2, 32'd1, 32'd6, 32'h0, 32'h0);
    checkOutput("model_2x2_count", 256'(exp_q.size()), 256'(4));
    checkOutput("model_2x2_id2_x", 256'(exp_q[2].cta_x), 256'(0));
    checkOutput("model_2x2_id2_y", 256'(exp_q[2].cta_y), 256'(1));
    checkOutput("model_2x2_nw", 256'(exp_q[3].num_warps), 256'(2));
    checkOutput("model_2x2_mask", 256'(exp_q[3].remain_mask), 256'(4'b0011));
    buildModel(32'd1, 32'd1, 32'd1, 32'd8, 32'h0, 32'h0);
    checkOutput("model_bs8_nw", 256'(exp_q[0].num_warps), 256'(2));
    checkOutput("model_bs8_mask", 256'(exp_q[0].remain_mask), 256'(4'b1111));
    buildModel(32'd2, 32'd1, 32'd1, 32'd17, 32'h0, 32'h0);
    checkOutput("model_bs17_err", 256'(exp_err), 256'(1'b1));
    buildModel(32'd3, 32'd1, 32'd2, 32'd4, 32'h0, 32'h0);
    checkOutput("model_3x1x2_z_at_id3", 256'(exp_q[3].cta_z), 256'(1));
    checkOutput("model_3x1x2_x_at_id3", 256'(exp_q[3].cta_x), 256'(0));
    exp_q.delete();

    // Launch scenarios: grid, block size, expected fires, done latency, error.
    runLaunch(32'd2, 32'd2, 32'd1, 32'd6, 4, 6, 1'b0);
    runLaunch(32'd1, 32'd1, 32'd1, 32'd8, 1, 3, 1'b0);
    runLaunch(32'd2, 32'd1, 32'd1, 32'd17, 0, 2, 1'b1);
    ready_toggle = 1'b1;
    runLaunch(32'd3, 32'd1, 32'd2, 32'd4, 6, -1, 1'b0);
    ready_toggle = 1'b0;
    req_ready    = 1'b1;
    runLaunch(32'd5, 32'd0, 32'd1, 32'd4, 0, 2, 1'b1);
    runLaunch(32'd1, 32'd1, 32'd1, 32'd0, 0, 2, 1'b1);

    // Reset in the middle of issuing: launch is dropped with no done pulse.
    applyStimulus(32'd4, 32'd1, 32'd1, 32'd4, 32'h4000, 32'h44);
    found = 1'b0;
    cnt   = 0;
    while (!found && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (req_valid && req_data.cta_id == 32'd2) found = 1'b1;
    end
    checkOutput("reset_test_reached_id2", 256'(found), 256'(1'b1));
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_req_valid", 256'(req_valid), 256'(1'b0));
    checkOutput("midreset_busy", 256'(busy), 256'(1'b0));
    checkOutput("midreset_start_ready", 256'(start_ready), 256'(1'b1));
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) cnt++;
    end
    checkOutput("midreset_no_done", 256'(cnt), 256'(0));
    exp_q.delete();
    stall_prev = 1'b0;
    mon_en     = 1'b1;

    runLaunch(32'd2, 32'd1, 32'd1, 32'd3, 2, 4, 1'b0);

`ifdef VX_KMU_ABORT_EN
    // Abort while the first request is stalled: it still fires, nothing follows.
    req_ready = 1'b0;
    applyStimulus(32'd4, 32'd1, 32'd1, 32'd4, 32'h5000, 32'h55);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    exp_err = 1'b1;
    found   = 1'b0;
    cnt     = 0;
    while (!found && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (req_valid) found = 1'b1;
    end
    checkOutput("abort_req_pending", 256'(found), 256'(1'b1));
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(posedge clk);
    #1;
    req_ready = 1'b1;
    waitDone(1, -1, 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
